// File: rtl/matrix_mult_sequencer.sv
// Purpose: arbitrates two requesters and walks a 4x4 matrix engine through load A, load B, read and capture.
// Latency: 5 cycles from grant to rsp_valid when the engine answers each handshake phase in one cycle.
// Backpressure: one operation in flight; requesters hold valid until their ready pulse, results wait for rsp_ready.
module matrix_mult_sequencer #(
  parameter int TIMEOUT  = 64,
  parameter bit RR_START = 1'b0
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         req0_valid,
  input  logic [255:0] req0_matA,
  input  logic [255:0] req0_matB,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [255:0] req1_matA,
  input  logic [255:0] req1_matB,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [255:0] rsp_data,
  output logic         rsp_err,
  input  logic         rsp_ready,
  output logic         mm_enable,
  output logic         mm_rw,
  output logic [255:0] mm_dataIn,
  input  logic [255:0] mm_dataOut,
  input  logic         mm_fleg,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, READ_REQ, READ_WAIT, CAPTURE, RESP
  } state_t;

  // Last count value still inside the allowed wait window.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           id_q, id_d;
  logic [255:0]   a_q, a_d;
  logic [255:0]   b_q, b_d;
  logic           req0_ready_q, req0_ready_d;
  logic           req1_ready_q, req1_ready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;
  logic [255:0]   rsp_data_q, rsp_data_d;
  logic           mm_enable_q, mm_enable_d;
  logic           mm_rw_q, mm_rw_d;
  logic [255:0]   mm_dataIn_q, mm_dataIn_d;
  logic           waiting;
  logic           timed_out;
  logic           abort;
  logic           gnt;

  // Next-state, arbitration, wait counter and registered engine/response outputs.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;
    abort        = 1'b0;
    gnt          = 1'b0;

    waiting   = (state_q == LOAD_A) || (state_q == LOAD_B) ||
                (state_q == READ_REQ) || (state_q == READ_WAIT);
    timed_out = waiting && (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // Contention goes to whoever was not served last; otherwise the lone requester wins.
          gnt          = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          last_d       = gnt;
          id_d         = gnt;
          a_d          = gnt ? req1_matA : req0_matA;
          b_d          = gnt ? req1_matB : req0_matB;
          req0_ready_d = ~gnt;
          req1_ready_d = gnt;
          state_d      = LOAD_A;
        end
      end
      // Exit conditions are tested before the timeout so a late handshake still completes.
      LOAD_A: begin
        if (mm_fleg) state_d = LOAD_B;
        else if (timed_out) abort = 1'b1;
      end
      LOAD_B: begin
        if (!mm_fleg) state_d = READ_REQ;
        else if (timed_out) abort = 1'b1;
      end
      READ_REQ: begin
        if (mm_fleg) state_d = READ_WAIT;
        else if (timed_out) abort = 1'b1;
      end
      READ_WAIT: begin
        if (!mm_fleg) state_d = CAPTURE;
        else if (timed_out) abort = 1'b1;
      end
      CAPTURE: begin
        rsp_data_d  = mm_dataOut;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_id_d    = id_q;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      rsp_data_d  = '0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_id_d    = id_q;
      state_d     = RESP;
    end

    // Counter restarts on every state change and only advances while waiting on the engine.
    if (state_d != state_q) cnt_d = '0;
    else if (waiting)       cnt_d = cnt_q + 16'd1;
    else                    cnt_d = cnt_q;

    // Engine strobes are decoded from the next state so they line up with the registered state.
    mm_enable_d = (state_d == LOAD_A) || (state_d == LOAD_B) ||
                  (state_d == READ_REQ) || (state_d == READ_WAIT);
    mm_rw_d     = (state_d == LOAD_A) || (state_d == LOAD_B);
    if (state_d == LOAD_A)      mm_dataIn_d = a_d;
    else if (state_d == LOAD_B) mm_dataIn_d = b_d;
    else                        mm_dataIn_d = '0;
  end

  // State and output registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_q       <= ~RR_START;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      mm_enable_q  <= 1'b0;
      mm_rw_q      <= 1'b0;
      mm_dataIn_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      req0_ready_q <= req0_ready_d;
      req1_ready_q <= req1_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
      mm_enable_q  <= mm_enable_d;
      mm_rw_q      <= mm_rw_d;
      mm_dataIn_q  <= mm_dataIn_d;
    end
  end

  assign req0_ready = req0_ready_q;
  assign req1_ready = req1_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign mm_enable  = mm_enable_q;
  assign mm_rw      = mm_rw_q;
  assign mm_dataIn  = mm_dataIn_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Bench for matrix_mult_sequencer: behavioural engine on the mm_* port, scoreboard of expected responses,
// table of operand vectors plus hand-written arbitration, timeout, backpressure and reset sequences.
module tb_matrix_mult_sequencer;

  logic         clk = 1'b0;
  logic         nReset = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [255:0] req0_matA = '0, req0_matB = '0, req1_matA = '0, req1_matB = '0;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_err;
  logic [255:0] rsp_data;
  logic         rsp_ready = 1'b0;
  logic         mm_enable, mm_rw;
  logic [255:0] mm_dataIn;
  logic [255:0] mm_dataOut = '0;
  logic         mm_fleg = 1'b0;
  logic         busy;

  matrix_mult_sequencer #(.TIMEOUT(8), .RR_START(1'b0)) dut (
    .clk(clk), .nReset(nReset),
    .req0_valid(req0_valid), .req0_matA(req0_matA), .req0_matB(req0_matB), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_matA(req1_matA), .req1_matB(req1_matB), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .mm_enable(mm_enable), .mm_rw(mm_rw), .mm_dataIn(mm_dataIn), .mm_dataOut(mm_dataOut),
    .mm_fleg(mm_fleg), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic id; logic [255:0] data; logic err; } exp_t;
  typedef struct { logic id; logic [255:0] a; logic [255:0] b; logic [255:0] exp; } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   stall   = 1'b0;
  int   phase   = 0;
  logic [255:0] ea = '0, eb = '0;

  function automatic logic [255:0] matmul(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    logic [15:0]  s;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 16'd0;
        for (int k = 0; k < 4; k++)
          s = s + a[i*64+16*k +: 16] * b[k*64+16*j +: 16];
        r[i*64+16*j +: 16] = s;
      end
    return r;
  endfunction

  function automatic logic [255:0] mat_fill(input logic [15:0] v);
    logic [255:0] r;
    for (int e = 0; e < 16; e++) r[e*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [255:0] mat_seq(input int start);
    logic [255:0] r;
    for (int e = 0; e < 16; e++) r[e*16 +: 16] = 16'(start + e);
    return r;
  endfunction

  function automatic logic [255:0] mat_ident();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*64+16*i +: 16] = 16'd1;
    return r;
  endfunction

  // Engine: one cycle per handshake phase; stall keeps the flag low to force a timeout.
  always @(negedge clk) begin
    if (!mm_enable) begin
      phase   = 0;
      mm_fleg = 1'b0;
    end else begin
      case (phase)
        0: if (mm_rw && !stall) begin ea = mm_dataIn; mm_fleg = 1'b1; phase = 1; end
        1: if (mm_rw) begin eb = mm_dataIn; mm_dataOut = matmul(ea, eb); mm_fleg = 1'b0; phase = 2; end
        2: if (!mm_rw) begin mm_fleg = 1'b1; phase = 3; end
        3: if (!mm_rw) begin mm_fleg = 1'b0; phase = 0; end
        default: phase = 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(output int who);
    who = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        chk("single_grant", {req0_ready, req1_ready} == 2'b11, 0);
        who = req1_ready ? 1 : 0;
        break;
      end
    end
    if (who < 0) begin
      n_tests++; n_fail++;
      $display("FAIL ready_wait: got no req_ready in 40 cycles want a pulse");
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rsp_valid) begin lat = i; break; end
    end
    if (lat < 0) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_wait: got no rsp_valid in 40 cycles want a response");
    end
  endtask

  task automatic check_rsp(input string name);
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: got a response want none pending", name);
    end else begin
      chk($sformatf("%s_data", name), rsp_data, sb[0].data);
      chk($sformatf("%s_ctrl", name), {rsp_valid, rsp_id, rsp_err}, {1'b1, sb[0].id, sb[0].err});
      chk($sformatf("%s_mm_idle", name), {mm_enable, mm_dataIn}, 0);
    end
  endtask

  task automatic handshake(input bit keep);
    if (sb.size() != 0) sb.delete(0);
    if (!keep) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_cleared", rsp_valid, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int who, lat;
    logic [255:0] a0, b0, a1, b1;

    vecs[0] = '{id: 1'b0, a: mat_ident(),       b: mat_seq(1),        exp: mat_seq(1)};
    vecs[1] = '{id: 1'b1, a: mat_fill(16'd2),   b: mat_fill(16'd3),   exp: mat_fill(16'h0018)};
    vecs[2] = '{id: 1'b0, a: mat_fill(16'h100), b: mat_fill(16'h100), exp: mat_fill(16'h0000)};
    vecs[3] = '{id: 1'b1, a: mat_seq(1),        b: mat_seq(5),        exp: matmul(mat_seq(1), mat_seq(5))};
    vecs[4] = '{id: 1'b0, a: mat_seq(9),        b: mat_ident(),       exp: mat_seq(9)};

    // Reset values with valid low.
    #12;
    chk("reset_ctrl", {busy, mm_enable, mm_rw, rsp_valid, rsp_err, rsp_id, req0_ready, req1_ready}, 0);
    chk("reset_data", rsp_data | mm_dataIn, 0);
    @(negedge clk);
    nReset = 1'b1;

    // Both requesters valid from reset: grants alternate 0,1,0,1 with one-cycle ready pulses.
    a0 = mat_seq(1); b0 = mat_seq(3); a1 = mat_seq(5); b1 = mat_ident();
    req0_matA = a0; req0_matB = b0; req1_matA = a1; req1_matB = b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ready(who);
      chk($sformatf("rr_order_%0d", k), who, k % 2);
      sb.push_back('{id: who[0], data: (who == 1) ? matmul(a1, b1) : matmul(a0, b0), err: 1'b0});
      @(negedge clk);
      chk($sformatf("rr_pulse_%0d", k), {req0_ready, req1_ready}, 0);
      wait_rsp(lat);
      check_rsp($sformatf("rr_rsp_%0d", k));
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      handshake(1'b1);
    end
    @(negedge clk);
    rsp_ready = 1'b0;

    // Operand table with the engine answering every phase in one cycle.
    for (int v = 0; v < 5; v++) begin
      if (vecs[v].id) begin req1_matA = vecs[v].a; req1_matB = vecs[v].b; req1_valid = 1'b1; end
      else            begin req0_matA = vecs[v].a; req0_matB = vecs[v].b; req0_valid = 1'b1; end
      wait_ready(who);
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk($sformatf("vec%0d_grant", v), who, vecs[v].id);
      sb.push_back('{id: vecs[v].id, data: vecs[v].exp, err: 1'b0});
      wait_rsp(lat);
      chk($sformatf("vec%0d_latency", v), lat, 5);
      check_rsp($sformatf("vec%0d", v));
      handshake(1'b0);
    end

    // Engine never raises the flag in LOAD_A: abort after 8 wait cycles.
    stall = 1'b1;
    req0_matA = mat_seq(2); req0_matB = mat_seq(4); req0_valid = 1'b1;
    wait_ready(who);
    req0_valid = 1'b0;
    chk("to_load_a", {mm_enable, mm_rw}, 2'b11);
    sb.push_back('{id: 1'b0, data: '0, err: 1'b1});
    wait_rsp(lat);
    chk("to_latency", lat, 8);
    check_rsp("timeout");
    handshake(1'b0);
    stall = 1'b0;

    // Consumer stalls 20 cycles while requester 1 waits; then no grant in the handshake cycle.
    req0_matA = mat_seq(2); req0_matB = mat_seq(9); req0_valid = 1'b1;
    wait_ready(who);
    req0_valid = 1'b0;
    sb.push_back('{id: 1'b0, data: matmul(mat_seq(2), mat_seq(9)), err: 1'b0});
    wait_rsp(lat);
    req1_matA = mat_seq(4); req1_matB = mat_fill(16'd1); req1_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("hold_data_%0d", c), rsp_data, sb[0].data);
      chk($sformatf("hold_ctrl_%0d", c), {rsp_valid, rsp_id, rsp_err, req0_ready, req1_ready, busy},
          {1'b1, sb[0].id, sb[0].err, 3'b001});
    end
    sb.delete(0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("release_no_grant", {rsp_valid, req0_ready, req1_ready, busy}, 0);
    wait_ready(who);
    req1_valid = 1'b0;
    chk("release_grant", who, 1);
    sb.push_back('{id: 1'b1, data: matmul(mat_seq(4), mat_fill(16'd1)), err: 1'b0});
    wait_rsp(lat);
    check_rsp("after_hold");
    handshake(1'b0);

    // Reset pulsed in READ_WAIT: outputs clear at once and the operation vanishes.
    req0_matA = mat_seq(7); req0_matB = mat_seq(2); req0_valid = 1'b1;
    wait_ready(who);
    req0_valid = 1'b0;
    sb.push_back('{id: 1'b0, data: matmul(mat_seq(7), mat_seq(2)), err: 1'b0});
    repeat (3) @(negedge clk);
    chk("rst_in_read_wait", {mm_enable, mm_rw}, 2'b10);
    #2 nReset = 1'b0;
    #1;
    chk("rst_async_ctrl", {busy, mm_enable, mm_rw, rsp_valid, rsp_err, rsp_id, req0_ready, req1_ready}, 0);
    chk("rst_async_data", rsp_data | mm_dataIn, 0);
    sb.delete();
    @(negedge clk);
    nReset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_no_rsp", {rsp_valid, busy}, 0);
    req0_matA = mat_seq(3); req0_matB = mat_fill(16'd2);
    req1_matA = mat_seq(8); req1_matB = mat_seq(1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_ready(who);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rst_first_grant", who, 0);
    sb.push_back('{id: 1'b0, data: matmul(mat_seq(3), mat_fill(16'd2)), err: 1'b0});
    wait_rsp(lat);
    chk("rst_latency", lat, 5);
    check_rsp("after_reset");
    handshake(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
